// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store data
// port share one main-memory port with a one-cycle read latency. Data
// normally wins a conflict. After STARVE_LIMIT consecutive denied fetch
// cycles, fetch wins the next conflict.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_stall,

    input  logic        i_d_req,
    input  logic        i_d_wr_en,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wr_val,
    input  logic [2:0]  i_d_l_s_sel,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,

    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_wr_val,
    output logic [2:0]  o_mem_wr_type,
    input  logic [31:0] i_mem_rd_val
);

    // Access-width selector encoding shared with the load/store unit.
    localparam logic [2:0] L_S_WORD = 3'd2;

    // Counter is wide enough to hold STARVE_LIMIT itself (and never zero width).
    localparam int              CW      = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0]   LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [CW-1:0]   ZERO_C  = CW'(0);

    // Who owns the memory response arriving next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t          owner_r;
    owner_t          owner_next_s;
    logic [CW-1:0]   starve_cnt_r;
    logic [CW-1:0]   starve_cnt_next_s;
    logic            fetch_priority_s;
    logic            if_gnt_s;
    logic            d_gnt_s;

    // Fetch takes priority once it has been denied STARVE_LIMIT cycles in a row.
    always_comb begin
        if (starve_cnt_r == LIMIT_C) begin
            fetch_priority_s = 1'b1;
        end else begin
            fetch_priority_s = 1'b0;
        end
    end

    // Grant selection: at most one grant, none while in reset.
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (i_rst) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (i_if_req && i_d_req) begin
            if (fetch_priority_s) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (i_d_req) begin
            d_gnt_s = 1'b1;
        end else if (i_if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Next owner and next starvation count from this cycle's grant.
    always_comb begin
        owner_next_s      = OWN_NONE;
        starve_cnt_next_s = ZERO_C;
        if (if_gnt_s) begin
            owner_next_s = OWN_IF;
        end else if (d_gnt_s) begin
            owner_next_s = OWN_DATA;
        end else begin
            owner_next_s = OWN_NONE;
        end

        if (!i_if_req || if_gnt_s) begin
            starve_cnt_next_s = ZERO_C;
        end else if (starve_cnt_r == LIMIT_C) begin
            starve_cnt_next_s = LIMIT_C;
        end else begin
            starve_cnt_next_s = starve_cnt_r + ONE_C;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner_r      <= OWN_NONE;
            starve_cnt_r <= ZERO_C;
        end else begin
            owner_r      <= owner_next_s;
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Grant, stall and memory-port drive (combinational, same cycle as grant).
    always_comb begin
        o_if_gnt     = if_gnt_s;
        o_d_gnt      = d_gnt_s;
        o_if_stall   = i_if_req & ~if_gnt_s;
        o_mem_wr_en  = d_gnt_s & i_d_wr_en;
        o_mem_wr_val = i_d_wr_val;
        if (d_gnt_s) begin
            o_mem_addr    = i_d_addr;
            o_mem_wr_type = i_d_l_s_sel;
        end else begin
            // Idle and fetch cycles both present the fetch address as a word read.
            o_mem_addr    = i_if_addr;
            o_mem_wr_type = L_S_WORD;
        end
    end

    // Response steering: the registered owner selects which port sees the
    // returning word; a reset in the response cycle drops the response.
    always_comb begin
        o_if_rvalid = 1'b0;
        o_d_rvalid  = 1'b0;
        o_if_rdata  = i_mem_rd_val;
        o_d_rdata   = i_mem_rd_val;
        case (owner_r)
            OWN_IF: begin
                o_if_rvalid = ~i_rst;
                o_d_rvalid  = 1'b0;
            end
            OWN_DATA: begin
                o_if_rvalid = 1'b0;
                o_d_rvalid  = ~i_rst;
            end
            OWN_NONE: begin
                o_if_rvalid = 1'b0;
                o_d_rvalid  = 1'b0;
            end
            default: begin
                o_if_rvalid = 1'b0;
                o_d_rvalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then held-until-granted random traffic, all watched by a
// per-cycle reference model and a one-cycle-latency memory model.
module tb_mem_arbiter;

    localparam int         LIMIT   = 4;
    localparam logic [2:0] LS_WORD = 3'd2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        o_if_stall;
    logic        i_d_req;
    logic        i_d_wr_en;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wr_val;
    logic [2:0]  i_d_l_s_sel;
    logic        o_d_gnt;
    logic        o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_val;
    logic [2:0]  o_mem_wr_type;
    logic [31:0] i_mem_rd_val;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_gnt     (o_if_gnt),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .o_if_stall   (o_if_stall),
        .i_d_req      (i_d_req),
        .i_d_wr_en    (i_d_wr_en),
        .i_d_addr     (i_d_addr),
        .i_d_wr_val   (i_d_wr_val),
        .i_d_l_s_sel  (i_d_l_s_sel),
        .o_d_gnt      (o_d_gnt),
        .o_d_rvalid   (o_d_rvalid),
        .o_d_rdata    (o_d_rdata),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_mem_wr_val (o_mem_wr_val),
        .o_mem_wr_type(o_mem_wr_type),
        .i_mem_rd_val (i_mem_rd_val)
    );

    // Main memory: word read data appears the cycle after the address,
    // reads see the value before a same-cycle write.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    assign i_mem_rd_val = rd_q;

    // Memory model clocked process.
    always @(posedge i_clk) begin
        rd_q <= mem[o_mem_addr[9:2]];
        if (o_mem_wr_en) mem[o_mem_addr[9:2]] <= o_mem_wr_val;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every cycle, derive the expected outputs from the
    // arbitration rules and the outstanding responses.
    int          m_wait    = 0;
    int          stall_run = 0;
    bit          p_if      = 1'b0;
    bit          p_d       = 1'b0;
    logic [31:0] p_if_data = 32'd0;
    logic [31:0] p_d_data  = 32'd0;

    initial begin
        forever begin
            logic        e_if;
            logic        e_d;
            logic [31:0] e_addr;
            @(negedge i_clk);
            e_if = 1'b0;
            e_d  = 1'b0;
            if (!i_rst) begin
                if (i_if_req && (!i_d_req || m_wait >= LIMIT)) e_if = 1'b1;
                else if (i_d_req) e_d = 1'b1;
            end
            e_addr = e_d ? i_d_addr : i_if_addr;

            chk("m_if_gnt", o_if_gnt, e_if);
            chk("m_d_gnt", o_d_gnt, e_d);
            chk("m_one_grant", o_if_gnt & o_d_gnt, 1'b0);
            chk("m_if_stall", o_if_stall, i_if_req & ~e_if);
            chk("m_mem_addr", o_mem_addr, e_addr);
            chk("m_mem_wr_en", o_mem_wr_en, e_d & i_d_wr_en);
            chk("m_mem_wr_val", o_mem_wr_val, i_d_wr_val);
            chk("m_mem_wr_type", o_mem_wr_type, e_d ? i_d_l_s_sel : LS_WORD);
            chk("m_if_rvalid", o_if_rvalid, p_if & ~i_rst);
            chk("m_d_rvalid", o_d_rvalid, p_d & ~i_rst);
            if (p_if && !i_rst) chk("m_if_rdata", o_if_rdata, p_if_data);
            if (p_d && !i_rst) chk("m_d_rdata", o_d_rdata, p_d_data);

            if (i_rst || !o_if_stall) stall_run = 0;
            else stall_run++;
            chk("m_starve_bound", (stall_run <= LIMIT), 1'b1);

            p_if      = e_if;
            p_d       = e_d;
            p_if_data = mem[e_addr[9:2]];
            p_d_data  = mem[e_addr[9:2]];
            if (i_rst || !i_if_req || e_if) m_wait = 0;
            else m_wait = m_wait + 1;
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    // Directed scenarios followed by random held-until-granted traffic.
    initial begin
        logic [5:0] d_pat;
        logic [5:0] f_pat;
        logic       gi;
        logic       gd;
        d_pat = 6'b101111;
        f_pat = 6'b010000;
        gi    = 1'b0;
        gd    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {24'hA5A5A5, 8'(i)};
        mem[8'h40] = 32'hDEADBEEF;

        i_rst       = 1'b1;
        i_if_req    = 1'b1;
        i_if_addr   = 32'h100;
        i_d_req     = 1'b0;
        i_d_wr_en   = 1'b0;
        i_d_addr    = 32'd0;
        i_d_wr_val  = 32'd0;
        i_d_l_s_sel = LS_WORD;

        // Reset holds every grant and response low even with a request pending.
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("rst_if_gnt", o_if_gnt, 1'b0);
            chk("rst_if_rvalid", o_if_rvalid, 1'b0);
            chk("rst_d_rvalid", o_d_rvalid, 1'b0);
            chk("rst_mem_wr_en", o_mem_wr_en, 1'b0);
            next_cycle();
        end

        // Fetch-only read of 0x100, granted in the first cycle out of reset.
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("fetch_first_gnt", o_if_gnt, 1'b1);
        next_cycle();
        i_if_req = 1'b0;
        @(negedge i_clk);
        chk("fetch_rvalid", o_if_rvalid, 1'b1);
        chk("fetch_rdata", o_if_rdata, 32'hDEADBEEF);

        // Conflict: data load 0x200 wins, fetch follows next cycle.
        next_cycle();
        i_if_req = 1'b1;
        i_if_addr = 32'h100;
        i_d_req = 1'b1;
        i_d_addr = 32'h200;
        @(negedge i_clk);
        chk("conf_d_gnt", o_d_gnt, 1'b1);
        chk("conf_if_stall", o_if_stall, 1'b1);
        next_cycle();
        i_d_req = 1'b0;
        @(negedge i_clk);
        chk("conf_if_gnt", o_if_gnt, 1'b1);
        chk("conf_d_rvalid", o_d_rvalid, 1'b1);
        chk("conf_d_rdata", o_d_rdata, 32'hA5A5A580);
        next_cycle();
        i_if_req = 1'b0;
        @(negedge i_clk);
        chk("conf_if_rdata", o_if_rdata, 32'hDEADBEEF);

        // Sustained conflict: data, data, data, data, fetch, data.
        next_cycle();
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            chk("starve_d_gnt", o_d_gnt, d_pat[k]);
            chk("starve_if_gnt", o_if_gnt, f_pat[k]);
            next_cycle();
        end
        i_if_req = 1'b0;
        i_d_req  = 1'b0;

        // Store 0x12345678 to 0x40, then fetch 0x40 and see the new word.
        next_cycle();
        i_d_req = 1'b1;
        i_d_wr_en = 1'b1;
        i_d_addr = 32'h40;
        i_d_wr_val = 32'h12345678;
        i_d_l_s_sel = LS_WORD;
        @(negedge i_clk);
        chk("st_wr_en", o_mem_wr_en, 1'b1);
        next_cycle();
        i_d_req = 1'b0;
        i_d_wr_en = 1'b0;
        i_if_req = 1'b1;
        i_if_addr = 32'h40;
        @(negedge i_clk);
        chk("st_wr_en_off", o_mem_wr_en, 1'b0);
        chk("st_d_rvalid", o_d_rvalid, 1'b1);
        chk("st_if_gnt", o_if_gnt, 1'b1);
        next_cycle();
        i_if_req = 1'b0;
        @(negedge i_clk);
        chk("st_fetch_rdata", o_if_rdata, 32'h12345678);

        // Reset right after a fetch grant drops its response.
        next_cycle();
        i_if_req = 1'b1;
        i_if_addr = 32'h100;
        @(negedge i_clk);
        chk("drop_if_gnt", o_if_gnt, 1'b1);
        next_cycle();
        i_if_req = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("drop_if_rvalid", o_if_rvalid, 1'b0);
        chk("drop_d_rvalid", o_d_rvalid, 1'b0);
        next_cycle();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("drop_after_rvalid", o_if_rvalid, 1'b0);
        next_cycle();

        // Random traffic; each requester holds its payload until granted.
        for (int n = 0; n < 10000; n++) begin
            if (!i_if_req || gi) begin
                i_if_req  = ($urandom_range(0, 3) != 0);
                i_if_addr = 32'($urandom_range(0, 63));
            end
            if (!i_d_req || gd) begin
                i_d_req     = ($urandom_range(0, 2) != 0);
                i_d_wr_en   = $urandom_range(0, 1) == 1;
                i_d_addr    = 32'($urandom_range(0, 63));
                i_d_wr_val  = $urandom;
                i_d_l_s_sel = 3'($urandom_range(0, 4));
            end
            i_rst = ($urandom_range(0, 499) == 0);
            @(negedge i_clk);
            gi = o_if_gnt;
            gd = o_d_gnt;
            next_cycle();
        end
        i_rst    = 1'b0;
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
